// File: rtl/i2c_pkg.sv
// Shared types and bus-level constants for the I2C target.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_ADDR,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

endpackage

// File: rtl/i2c_if.sv
// Register-side port bundle of the I2C target (pointer, write strobe, read data, busy).
interface i2c_if;
  logic [7:0] reg_addr_o;
  logic [7:0] reg_wdata_o;
  logic       reg_wr_en_o;
  logic [7:0] reg_rdata_i;
  logic       busy_o;

  modport slave  (output reg_addr_o, reg_wdata_o, reg_wr_en_o, busy_o, input reg_rdata_i);
  modport master (input reg_addr_o, reg_wdata_o, reg_wr_en_o, busy_o, output reg_rdata_i);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer chain plus one history flop for a slow bus line; reports the
// history value and single-cycle rise/fall strobes. Resets to 1 (idle bus).
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic prev_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = line_i;
    hist_d    = sync_q[STAGES-1];
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign prev_o = hist_q;
  assign rise_o = sync_q[STAGES-1] & ~hist_q;
  assign fall_o = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/i2c_target.sv
// I2C register target: 7-bit address, register pointer with auto-increment,
// write strobe per data byte and streamed reads; scl is treated as data only.
//
// state    | meaning
// IDLE     | bus free or not yet addressed
// DEV_ADDR | shifting in device address + R/W
// DEV_ACK  | acknowledging device address
// REG_ADDR | shifting in register pointer
// REG_ACK  | acknowledging register pointer
// WR_DATA  | shifting in a write data byte
// WR_ACK   | acknowledging a write data byte
// RD_DATA  | shifting out a read data byte
// RD_ACK   | sampling the initiator's ACK/NACK
// IGNORE   | not addressed or NACKed, wait for START/STOP
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEVICE_ADDR = 7'h21,
  parameter int         SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic scl_i,
  inout  wire  sda_io,
  i2c_if.slave reg_if
);

  logic scl_prev, scl_rise, scl_fall;
  logic sda_prev, sda_rise, sda_fall;
  logic start, stop;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .line_i (scl_i),
    .prev_o (scl_prev),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .line_i (sda_io),
    .prev_o (sda_prev),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  // Compare against the older scl so a coincident scl edge cannot fake START/STOP.
  assign start = sda_fall & scl_prev;
  assign stop  = sda_rise & scl_prev;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_low_q, sda_low_d;
  logic       rw_q, rw_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] reg_wdata_q, reg_wdata_d;
  logic       wr_en_q, wr_en_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_byte;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    sda_low_d   = sda_low_q;
    rw_d        = rw_q;
    reg_addr_d  = wr_en_q ? reg_addr_q + 8'd1 : reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    wr_en_d     = 1'b0;
    busy_d      = busy_q;
    rx_byte     = {shift_q[6:0], sda_prev};

    if (stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (start) begin
      state_d   = DEV_ADDR;
      bit_cnt_d = '0;
      sda_low_d = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR, REG_ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              if (state_q == DEV_ADDR) begin
                if (rx_byte[7:1] == DEVICE_ADDR) begin
                  state_d = DEV_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == REG_ADDR) begin
                reg_addr_d = rx_byte;
                state_d    = REG_ACK;
              end else begin
                reg_wdata_d = rx_byte;
                wr_en_d     = 1'b1;
                state_d     = WR_ACK;
              end
            end
          end
        end
        DEV_ACK, REG_ACK, WR_ACK: begin
          // First scl fall starts the ACK, second one ends it.
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              bit_cnt_d = '0;
              if (state_q == DEV_ACK && rw_q) begin
                state_d   = RD_DATA;
                shift_d   = reg_if.reg_rdata_i;
                sda_low_d = ~reg_if.reg_rdata_i[7];
              end else if (state_q == DEV_ACK) begin
                state_d = REG_ADDR;
              end else begin
                state_d = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_low_d = 1'b0;
              state_d   = RD_ACK;
            end else begin
              sda_low_d = ~shift_q[7];
            end
          end
        end
        RD_ACK: begin
          // bit_cnt 9 marks an ACK seen; the next byte is loaded on the fall.
          if (scl_rise) begin
            if (sda_prev == NACK) begin
              state_d = IGNORE;
            end else begin
              reg_addr_d = reg_addr_q + 8'd1;
              bit_cnt_d  = 4'd9;
            end
          end else if (scl_fall && bit_cnt_q == 4'd9) begin
            state_d   = RD_DATA;
            bit_cnt_d = '0;
            shift_d   = reg_if.reg_rdata_i;
            sda_low_d = ~reg_if.reg_rdata_i[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      sda_low_q   <= 1'b0;
      rw_q        <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      sda_low_q   <= sda_low_d;
      rw_q        <= rw_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_io             = sda_low_q ? 1'b0 : 1'bz;
  assign reg_if.reg_addr_o  = reg_addr_q;
  assign reg_if.reg_wdata_o = reg_wdata_q;
  assign reg_if.reg_wr_en_o = wr_en_q;
  assign reg_if.busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: transaction vector table plus hand-written
// partial-byte STOP and reset-during-ACK sequences.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst;
  logic scl;
  logic sda_m_low;
  wire  sda_w;
  logic [7:0] mem [256];

  i2c_if reg_if ();

  assign sda_w = sda_m_low ? 1'b0 : 1'bz;
  pullup (sda_w);
  assign reg_if.reg_rdata_i = mem[reg_if.reg_addr_o];

  i2c_target #(.DEVICE_ADDR(7'h21), .SYNC_STAGES(2)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .scl_i  (scl),
    .sda_io (sda_w),
    .reg_if (reg_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [15:0] pulses [$];

  always @(negedge clk)
    if (reg_if.reg_wr_en_o) pulses.push_back({reg_if.reg_addr_o, reg_if.reg_wdata_o});

  typedef enum logic [2:0] {OP_START, OP_STOP, OP_WR, OP_RD, OP_PULSE, OP_NOPULSE, OP_ADDR, OP_BUSY} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] arg;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [$];

  function automatic void add(op_e op, logic [7:0] arg, logic [7:0] exp);
    vec_t v;
    v.op = op; v.arg = arg; v.exp = exp;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%02h required=%02h", name, act, exp);
    end
  endtask

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic send_bit(logic b);
    sda_m_low = ~b;
    qwait(); scl = 1'b1; qwait(); qwait(); scl = 1'b0; qwait();
  endtask

  task automatic i2c_start();
    sda_m_low = 1'b0; qwait(); scl = 1'b1; qwait();
    sda_m_low = 1'b1; qwait(); scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m_low = 1'b1; qwait(); scl = 1'b1; qwait();
    sda_m_low = 1'b0; qwait();
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m_low = 1'b0; qwait(); scl = 1'b1; qwait();
    ack = sda_w;
    qwait(); scl = 1'b0; qwait();
  endtask

  task automatic read_byte(input logic ackb, output logic [7:0] d);
    sda_m_low = 1'b0;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      qwait(); scl = 1'b1; qwait();
      d = {d[6:0], sda_w};
      qwait(); scl = 1'b0;
    end
    qwait();
    send_bit(ackb);
  endtask

  task automatic run_vectors();
    logic       ack;
    logic [7:0] d;
    logic [15:0] p;
    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_START: i2c_start();
        OP_STOP: begin
          i2c_stop();
          qwait();
          check($sformatf("v%0d_sda_idle", i), {7'd0, sda_w}, 8'd1);
        end
        OP_WR: begin
          write_byte(vecs[i].arg, ack);
          check($sformatf("v%0d_ack", i), {7'd0, ack}, vecs[i].exp);
        end
        OP_RD: begin
          read_byte(vecs[i].arg[0], d);
          check($sformatf("v%0d_rdata", i), d, vecs[i].exp);
        end
        OP_PULSE: begin
          if (pulses.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d_pulse: actual=none required=addr %02h data %02h", i, vecs[i].arg, vecs[i].exp);
          end else begin
            p = pulses.pop_front();
            check($sformatf("v%0d_pulse_addr", i), p[15:8], vecs[i].arg);
            check($sformatf("v%0d_pulse_data", i), p[7:0], vecs[i].exp);
          end
        end
        OP_NOPULSE: begin
          check($sformatf("v%0d_pulse_count", i), 8'(pulses.size()), 8'd0);
          pulses.delete();
        end
        OP_ADDR: check($sformatf("v%0d_addr", i), reg_if.reg_addr_o, vecs[i].exp);
        OP_BUSY: check($sformatf("v%0d_busy", i), {7'd0, reg_if.busy_o}, vecs[i].exp);
        default: ;
      endcase
    end
    vecs.delete();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic ack;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h0A] = 8'h76;
    mem[8'h0B] = 8'h73;
    rst = 1'b1; scl = 1'b1; sda_m_low = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_addr", reg_if.reg_addr_o, 8'h00);
    check("rst_wdata", reg_if.reg_wdata_o, 8'h00);
    check("rst_wr_en", {7'd0, reg_if.reg_wr_en_o}, 8'd0);
    check("rst_busy", {7'd0, reg_if.busy_o}, 8'd0);
    check("rst_sda", {7'd0, sda_w}, 8'd1);
    rst = 1'b0;
    qwait();

    // single write
    add(OP_START, 0, 0); add(OP_WR, 8'h42, ACK); add(OP_BUSY, 0, 1);
    add(OP_WR, 8'h12, ACK); add(OP_WR, 8'h80, ACK); add(OP_STOP, 0, 0);
    add(OP_BUSY, 0, 0); add(OP_PULSE, 8'h12, 8'h80); add(OP_NOPULSE, 0, 0);
    add(OP_ADDR, 0, 8'h13);
    // burst write across the pointer wrap
    add(OP_START, 0, 0); add(OP_WR, 8'h42, ACK); add(OP_WR, 8'hFE, ACK);
    add(OP_WR, 8'h11, ACK); add(OP_WR, 8'h22, ACK); add(OP_WR, 8'h33, ACK);
    add(OP_STOP, 0, 0); add(OP_PULSE, 8'hFE, 8'h11); add(OP_PULSE, 8'hFF, 8'h22);
    add(OP_PULSE, 8'h00, 8'h33); add(OP_NOPULSE, 0, 0); add(OP_ADDR, 0, 8'h01);
    // pointer set, repeated start, two-byte read ending in NACK
    add(OP_START, 0, 0); add(OP_WR, 8'h42, ACK); add(OP_WR, 8'h0A, ACK);
    add(OP_START, 0, 0); add(OP_WR, 8'h43, ACK); add(OP_ADDR, 0, 8'h0A);
    add(OP_RD, {7'd0, ACK}, 8'h76); add(OP_RD, {7'd0, NACK}, 8'h73);
    add(OP_STOP, 0, 0); add(OP_ADDR, 0, 8'h0B); add(OP_NOPULSE, 0, 0);
    // foreign address
    add(OP_START, 0, 0); add(OP_WR, 8'h60, NACK); add(OP_BUSY, 0, 0);
    add(OP_WR, 8'h55, NACK); add(OP_STOP, 0, 0); add(OP_NOPULSE, 0, 0);
    add(OP_BUSY, 0, 0); add(OP_ADDR, 0, 8'h0B);
    run_vectors();

    // STOP after half a data byte
    i2c_start();
    write_byte(8'h42, ack); check("part_ack0", {7'd0, ack}, 8'd0);
    write_byte(8'h05, ack); check("part_ack1", {7'd0, ack}, 8'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i2c_stop();
    qwait();
    check("part_busy", {7'd0, reg_if.busy_o}, 8'd0);
    check("part_sda", {7'd0, sda_w}, 8'd1);
    check("part_addr", reg_if.reg_addr_o, 8'h05);
    add(OP_NOPULSE, 0, 0);
    add(OP_START, 0, 0); add(OP_WR, 8'h42, ACK); add(OP_WR, 8'h06, ACK);
    add(OP_WR, 8'h5A, ACK); add(OP_STOP, 0, 0); add(OP_PULSE, 8'h06, 8'h5A);
    add(OP_NOPULSE, 0, 0);
    run_vectors();

    // reset while the target is holding the ACK low
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'((8'h42 >> i) & 8'h01));
    sda_m_low = 1'b0;
    check("rack_driven", {7'd0, sda_w}, 8'd0);
    check("rack_busy", {7'd0, reg_if.busy_o}, 8'd1);
    rst = 1'b1;
    #1;
    check("rack_sda", {7'd0, sda_w}, 8'd1);
    check("rack_addr", reg_if.reg_addr_o, 8'h00);
    check("rack_wdata", reg_if.reg_wdata_o, 8'h00);
    check("rack_wr_en", {7'd0, reg_if.reg_wr_en_o}, 8'd0);
    check("rack_busy_clr", {7'd0, reg_if.busy_o}, 8'd0);
    @(negedge clk);
    scl = 1'b1;
    qwait();
    rst = 1'b0;
    qwait();
    add(OP_NOPULSE, 0, 0);
    add(OP_START, 0, 0); add(OP_WR, 8'h42, ACK); add(OP_WR, 8'h30, ACK);
    add(OP_WR, 8'hC3, ACK); add(OP_STOP, 0, 0); add(OP_PULSE, 8'h30, 8'hC3);
    add(OP_NOPULSE, 0, 0); add(OP_ADDR, 0, 8'h31);
    run_vectors();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
